// File: rtl/obc_dft_pkg.sv
// rtl/obc_dft_pkg.sv - shared OBC DFT widths and accumulator state type
package obc_dft_pkg;

    localparam int DATA_W  = 32;
    localparam int IN_BITS = 8;
    localparam int NUM_ROM = 8;
    localparam int SUM_W   = DATA_W + $clog2(NUM_ROM);
    localparam int ACC_W   = SUM_W + IN_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL
    } state_t;

endpackage

// File: rtl/obc_shift_accumulator_if.sv
// rtl/obc_shift_accumulator_if.sv - slice/result bundle for the OBC shift accumulator (sat_flag under OBC_SAT_EN)
interface obc_shift_accumulator_if #(
    parameter int DATA_W  = obc_dft_pkg::DATA_W,
    parameter int IN_BITS = obc_dft_pkg::IN_BITS
);
    localparam int ACC_W = DATA_W + 3 + IN_BITS;

    logic                     start;
    logic signed [DATA_W-1:0] offset_in;
    logic                     slice_valid;
    logic signed [DATA_W-1:0] rom_in0;
    logic signed [DATA_W-1:0] rom_in1;
    logic signed [DATA_W-1:0] rom_in2;
    logic signed [DATA_W-1:0] rom_in3;
    logic signed [DATA_W-1:0] rom_in4;
    logic signed [DATA_W-1:0] rom_in5;
    logic signed [DATA_W-1:0] rom_in6;
    logic signed [DATA_W-1:0] rom_in7;
    logic                     busy;
    logic signed [ACC_W-1:0]  y_out;
    logic                     y_valid;
`ifdef OBC_SAT_EN
    logic                     sat_flag;
`endif

    modport master (
        input  busy, y_out, y_valid,
`ifdef OBC_SAT_EN
        input  sat_flag,
`endif
        output start, offset_in, slice_valid,
        output rom_in0, rom_in1, rom_in2, rom_in3,
        output rom_in4, rom_in5, rom_in6, rom_in7
    );

    modport slave (
        output busy, y_out, y_valid,
`ifdef OBC_SAT_EN
        output sat_flag,
`endif
        input  start, offset_in, slice_valid,
        input  rom_in0, rom_in1, rom_in2, rom_in3,
        input  rom_in4, rom_in5, rom_in6, rom_in7
    );

endinterface

// File: rtl/obc_slice_adder.sv
// rtl/obc_slice_adder.sv - combinational signed 8-input adder tree for one bit-slice
module obc_slice_adder #(
    parameter int DATA_W = obc_dft_pkg::DATA_W,
    parameter int SUM_W  = obc_dft_pkg::SUM_W
) (
    input  logic signed [DATA_W-1:0] rom_in0,
    input  logic signed [DATA_W-1:0] rom_in1,
    input  logic signed [DATA_W-1:0] rom_in2,
    input  logic signed [DATA_W-1:0] rom_in3,
    input  logic signed [DATA_W-1:0] rom_in4,
    input  logic signed [DATA_W-1:0] rom_in5,
    input  logic signed [DATA_W-1:0] rom_in6,
    input  logic signed [DATA_W-1:0] rom_in7,
    output logic signed [SUM_W-1:0]  sum
);

    // Every level is carried at SUM_W so the three growth bits absorb all carries.
    logic signed [SUM_W-1:0] l1_0, l1_1, l1_2, l1_3;
    logic signed [SUM_W-1:0] l2_0, l2_1;

    assign l1_0 = SUM_W'(rom_in0) + SUM_W'(rom_in1);
    assign l1_1 = SUM_W'(rom_in2) + SUM_W'(rom_in3);
    assign l1_2 = SUM_W'(rom_in4) + SUM_W'(rom_in5);
    assign l1_3 = SUM_W'(rom_in6) + SUM_W'(rom_in7);
    assign l2_0 = l1_0 + l1_1;
    assign l2_1 = l1_2 + l1_3;
    assign sum  = l2_0 + l2_1;

endmodule

// File: rtl/obc_shift_accumulator.sv
// rtl/obc_shift_accumulator.sv - LSB-first OBC bit-slice accumulator producing one DFT component per frame (optional clamp: OBC_SAT_EN)
module obc_shift_accumulator #(
    parameter int DATA_W  = obc_dft_pkg::DATA_W,
    parameter int IN_BITS = obc_dft_pkg::IN_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    obc_shift_accumulator_if.slave bus
);
    import obc_dft_pkg::*;

    localparam int SUM_W = DATA_W + 3;
    localparam int ACC_W = SUM_W + IN_BITS;
    localparam int IDX_W = $clog2(IN_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_BITS - 1);

    state_t                   state, state_nxt;
    logic signed [SUM_W-1:0]  s;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic signed [ACC_W-1:0]  shifted, total;
    logic signed [ACC_W-1:0]  y_out_q, y_out_nxt;
    logic signed [DATA_W-1:0] offset_reg, offset_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic                     busy_q, busy_nxt;
    logic                     yv_q, yv_nxt;
`ifdef OBC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic                     sat_q, sat_nxt;
`endif

    obc_slice_adder #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_slice_adder (
        .rom_in0 (bus.rom_in0),
        .rom_in1 (bus.rom_in1),
        .rom_in2 (bus.rom_in2),
        .rom_in3 (bus.rom_in3),
        .rom_in4 (bus.rom_in4),
        .rom_in5 (bus.rom_in5),
        .rom_in6 (bus.rom_in6),
        .rom_in7 (bus.rom_in7),
        .sum     (s)
    );

    assign shifted = ACC_W'(s) << idx;
    assign total   = acc + ACC_W'(offset_reg);

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        idx_nxt    = idx;
        offset_nxt = offset_reg;
        busy_nxt   = busy_q;
        y_out_nxt  = y_out_q;
        yv_nxt     = 1'b0;
`ifdef OBC_SAT_EN
        sat_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt    = '0;
                    idx_nxt    = '0;
                    offset_nxt = bus.offset_in;
                    busy_nxt   = 1'b1;
                    state_nxt  = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.slice_valid) begin
                    // The MSB slice carries the sign weight of the two's-complement input.
                    if (idx == LAST_IDX) begin
                        acc_nxt   = acc - shifted;
                        state_nxt = FINAL;
                    end else begin
                        acc_nxt = acc + shifted;
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            FINAL: begin
`ifdef OBC_SAT_EN
                if (total > SAT_MAX) begin
                    y_out_nxt = SAT_MAX;
                    sat_nxt   = 1'b1;
                end else if (total < SAT_MIN) begin
                    y_out_nxt = SAT_MIN;
                    sat_nxt   = 1'b1;
                end else begin
                    y_out_nxt = total;
                end
`else
                y_out_nxt = total;
`endif
                yv_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            offset_reg <= '0;
            busy_q     <= 1'b0;
            y_out_q    <= '0;
            yv_q       <= 1'b0;
`ifdef OBC_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            idx        <= idx_nxt;
            offset_reg <= offset_nxt;
            busy_q     <= busy_nxt;
            y_out_q    <= y_out_nxt;
            yv_q       <= yv_nxt;
`ifdef OBC_SAT_EN
            sat_q      <= sat_nxt;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = yv_q;
`ifdef OBC_SAT_EN
    assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// tb/tb_obc_shift_accumulator.sv - directed-vector bench for obc_shift_accumulator (OBC_SAT_EN aware)
module tb_obc_shift_accumulator;

    localparam int ACC_W = 43;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic [31:0] rom_tab [8][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obc_shift_accumulator_if bus ();

    obc_shift_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slice(input int k);
        bus.rom_in0 = rom_tab[k][0];
        bus.rom_in1 = rom_tab[k][1];
        bus.rom_in2 = rom_tab[k][2];
        bus.rom_in3 = rom_tab[k][3];
        bus.rom_in4 = rom_tab[k][4];
        bus.rom_in5 = rom_tab[k][5];
        bus.rom_in6 = rom_tab[k][6];
        bus.rom_in7 = rom_tab[k][7];
    endtask

    task automatic drive_junk;
        bus.rom_in0 = 32'd1000;
        bus.rom_in1 = 32'd1000;
        bus.rom_in2 = 32'd1000;
        bus.rom_in3 = 32'd1000;
        bus.rom_in4 = 32'd1000;
        bus.rom_in5 = 32'd1000;
        bus.rom_in6 = 32'd1000;
        bus.rom_in7 = 32'd1000;
    endtask

    task automatic tab_fill(input logic [31:0] v, input int last);
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 8; w++)
                rom_tab[s][w] = (s <= last) ? v : 32'd0;
    endtask

    task automatic tab_one(input int slice, input logic [31:0] v);
        tab_fill(32'd0, -1);
        rom_tab[slice][0] = v;
    endtask

    // Caller must be at #1 after a rising edge; leaves at #1 after the edge that raised y_valid.
    task automatic run_frame(input logic [31:0] offset, input int gap_a, input int gap_b,
                             input int gap_len, input bit junk_with_start, input int start_mid,
                             output logic signed [ACC_W-1:0] y, output int lat,
                             output bit busy_ok, output bit sat);
        int t0;
        busy_ok = 1'b1;
        y = '0;
        lat = -1;
        sat = 1'b0;
        t0 = cyc;
        bus.start = 1'b1;
        bus.offset_in = offset;
        if (junk_with_start) begin
            bus.slice_valid = 1'b1;
            drive_junk();
        end
        tick();
        bus.start = 1'b0;
        bus.offset_in = 32'hDEAD0000;
        for (int k = 0; k < 8; k++) begin
            bus.slice_valid = 1'b1;
            drive_slice(k);
            bus.start = (k == start_mid);
            tick();
            bus.start = 1'b0;
            bus.slice_valid = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (k == gap_a || k == gap_b) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive_junk();
                    tick();
                    if (!bus.busy) busy_ok = 1'b0;
                end
            end
        end
        for (int n = 0; n < 40; n++) begin
            if (bus.y_valid) break;
            tick();
        end
        if (bus.y_valid) begin
            lat = cyc - t0;
            y = bus.y_out;
`ifdef OBC_SAT_EN
            sat = bus.sat_flag;
`endif
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.slice_valid = 1'b0;
        bus.offset_in = '0;
        tab_fill(32'd0, -1);
        drive_slice(0);
        tick();
        tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.y_out !== '0) begin miscompares++; $display("FAIL reset_y_out: got %0d expected 0", bus.y_out); end
        vectors++; if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid: got %b expected 0", bus.y_valid); end
`ifdef OBC_SAT_EN
        vectors++; if (bus.sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flag: got %b expected 0", bus.sat_flag); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic signed [ACC_W-1:0] y;
        int lat;
        bit bok, sat;
        tab_fill(32'd1, 7);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, y, lat, bok, sat);
        vectors++; if (y !== -43'sd8) begin miscompares++; $display("FAIL basic_y: got %0d expected -8", y); end
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL basic_latency: got %0d expected 10", lat); end
        vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b expected 1", bok); end
        tick();
        vectors++; if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: got %b expected 0", bus.y_valid); end
        vectors++; if (bus.y_out !== -43'sd8) begin miscompares++; $display("FAIL basic_hold: got %0d expected -8", bus.y_out); end
    endtask

    task automatic test_offset_and_weights;
        logic signed [ACC_W-1:0] y;
        int lat;
        bit bok, sat;
        tab_fill(32'd1, 7);
        run_frame(32'd5, -1, -1, 0, 1'b0, -1, y, lat, bok, sat);
        vectors++; if (y !== -43'sd3) begin miscompares++; $display("FAIL offset_y: got %0d expected -3", y); end
        tick();
        tab_one(0, 32'd16);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, y, lat, bok, sat);
        vectors++; if (y !== 43'sd16) begin miscompares++; $display("FAIL lsb_slice_y: got %0d expected 16", y); end
        tick();
        tab_one(7, 32'd1);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, y, lat, bok, sat);
        vectors++; if (y !== -43'sd128) begin miscompares++; $display("FAIL msb_slice_y: got %0d expected -128", y); end
`ifdef OBC_SAT_EN
        vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL msb_slice_sat: got %b expected 0", sat); end
`endif
        tick();
    endtask

    task automatic test_gaps;
        logic signed [ACC_W-1:0] y;
        int lat;
        bit bok, sat;
        tab_fill(32'd1, 7);
        run_frame(32'd0, 2, 5, 3, 1'b0, -1, y, lat, bok, sat);
        vectors++; if (y !== -43'sd8) begin miscompares++; $display("FAIL gaps_y: got %0d expected -8", y); end
        vectors++; if (lat !== 16) begin miscompares++; $display("FAIL gaps_latency: got %0d expected 16", lat); end
        vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL gaps_busy: got %b expected 1", bok); end
        tick();
    endtask

    task automatic test_reset_mid_frame;
        logic signed [ACC_W-1:0] y;
        int lat;
        bit bok, sat;
        tab_fill(32'h00001234, 7);
        bus.start = 1'b1;
        bus.offset_in = 32'd77;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.slice_valid = 1'b1;
            drive_slice(k);
            tick();
        end
        bus.slice_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.y_out !== '0) begin miscompares++; $display("FAIL abort_y_out: got %0d expected 0", bus.y_out); end
        vectors++; if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL abort_y_valid: got %b expected 0", bus.y_valid); end
        tick();
        rst = 1'b0;
        tick();
        tab_fill(32'd1, 7);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, y, lat, bok, sat);
        vectors++; if (y !== -43'sd8) begin miscompares++; $display("FAIL abort_restart_y: got %0d expected -8", y); end
        tick();
    endtask

    task automatic test_ignored_controls;
        logic signed [ACC_W-1:0] y;
        int lat;
        bit bok, sat;
        tab_fill(32'd1, 7);
        run_frame(32'd0, -1, -1, 0, 1'b1, 3, y, lat, bok, sat);
        vectors++; if (y !== -43'sd8) begin miscompares++; $display("FAIL ignore_y: got %0d expected -8", y); end
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 10", lat); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic signed [ACC_W-1:0] ya, yb;
        int lata, latb;
        bit boka, bokb, sata, satb;
        tab_fill(32'd1, 7);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, ya, lata, boka, sata);
        tab_one(0, 32'd16);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, yb, latb, bokb, satb);
        vectors++; if (ya !== -43'sd8) begin miscompares++; $display("FAIL b2b_first_y: got %0d expected -8", ya); end
        vectors++; if (yb !== 43'sd16) begin miscompares++; $display("FAIL b2b_second_y: got %0d expected 16", yb); end
        vectors++; if (latb !== 10) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 10", latb); end
        tick();
    endtask

    task automatic test_saturation;
        logic signed [ACC_W-1:0] y, exp_y;
        int lat;
        bit bok, sat;
        tab_fill(32'h7FFFFFFF, 6);
        run_frame(32'd0, -1, -1, 0, 1'b0, -1, y, lat, bok, sat);
`ifdef OBC_SAT_EN
        exp_y = 43'sd2147483647;
        vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat_flag: got %b expected 1", sat); end
`else
        exp_y = 43'sd1016 * 43'sd2147483647;
`endif
        vectors++; if (y !== exp_y) begin miscompares++; $display("FAIL sat_y: got %0d expected %0d", y, exp_y); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset_and_weights();
        test_gaps();
        test_reset_mid_frame();
        test_ignored_controls();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
